// File: rtl/vec_rf_rd_arb.sv
// Purpose : round-robin arbiter sharing RPORT register-file read ports among NREQ
//           operand-fetch requesters; routes returned read data back to the issuer.
// Latency : handshake at edge E -> rf_rd_en high after E -> rsp_valid high after edge E+1+RF_LAT.
// Backpressure: req_ready is the grant (at most RPORT per cycle); responses cannot be stalled.
//
// Ports:
//   clk, rst_n (sync, active-low), clk_en (global hold when low)
//   req_valid/req_addr/req_ready : per-requester read request and grant
//   rf_rd_en/rf_rd_addr          : registered register-file read port controls
//   rf_rd_data                   : register-file data, valid RF_LAT cycles after rf_rd_en
//   rsp_valid/rsp_data           : registered per-requester read response
module vec_rf_rd_arb #(
  parameter int NREQ   = 4,
  parameter int RPORT  = 2,
  parameter int XLEN   = 64,
  parameter int RF_LAT = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clk_en,
  input  logic [NREQ-1:0]                  req_valid,
  input  logic [NREQ-1:0][4:0]             req_addr,
  output logic [NREQ-1:0]                  req_ready,
  output logic [RPORT-1:0]                 rf_rd_en,
  output logic [RPORT-1:0][4:0]            rf_rd_addr,
  input  logic [RPORT-1:0][XLEN-1:0]       rf_rd_data,
  output logic [NREQ-1:0]                  rsp_valid,
  output logic [NREQ-1:0][XLEN-1:0]        rsp_data
);

  localparam int IDW = $clog2(NREQ);
  localparam int SW  = IDW + 1;
  // Stage 0 of the tag pipeline travels alongside rf_rd_en; the remaining
  // RF_LAT stages cover the register-file access, so the last stage lines up
  // with the cycle in which rf_rd_data is valid.
  localparam int TD  = RF_LAT + 1;

  logic [IDW-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [RPORT-1:0]                  gnt_vld;
  logic [RPORT-1:0][IDW-1:0]         gnt_id;

  logic [RPORT-1:0]                  rf_rd_en_q, rf_rd_en_d;
  logic [RPORT-1:0][4:0]             rf_rd_addr_q, rf_rd_addr_d;
  logic [RPORT-1:0][TD-1:0]          tag_vld_q, tag_vld_d;
  logic [RPORT-1:0][TD-1:0][IDW-1:0] tag_id_q, tag_id_d;
  logic [NREQ-1:0]                   rsp_valid_q, rsp_valid_d;
  logic [NREQ-1:0][XLEN-1:0]         rsp_data_q, rsp_data_d;

  // ---------------------------------------------------------------------------
  // Grant: scan from rr_ptr, hand the first RPORT valid requesters to ports
  // 0..RPORT-1 in scan order. Depends only on req_valid and rr_ptr.
  // ---------------------------------------------------------------------------
  always_comb begin : p_grant
    logic [SW-1:0]  scan_sum;
    logic [IDW-1:0] scan_id;
    logic           placed;
    scan_sum  = '0;
    scan_id   = '0;
    placed    = 1'b0;
    gnt_vld   = '0;
    gnt_id    = '0;
    req_ready = '0;
    rr_ptr_d  = rr_ptr_q;
    if (clk_en && rst_n) begin
      for (int o = 0; o < NREQ; o++) begin
        // (rr_ptr + o) mod NREQ without a divider; NREQ need not be a power of two.
        scan_sum = {1'b0, rr_ptr_q} + SW'(o);
        if (scan_sum >= SW'(NREQ)) begin
          scan_sum = scan_sum - SW'(NREQ);
        end
        scan_id = scan_sum[IDW-1:0];
        placed  = 1'b0;
        if (req_valid[scan_id]) begin
          // First free port is port k where k = number of grants so far.
          for (int k = 0; k < RPORT; k++) begin
            if (!placed && !gnt_vld[k]) begin
              gnt_vld[k] = 1'b1;
              gnt_id[k]  = scan_id;
              placed     = 1'b1;
            end
          end
        end
        if (placed) begin
          req_ready[scan_id] = 1'b1;
          // Later grants overwrite earlier ones, leaving last-granted id + 1.
          rr_ptr_d = (scan_id == IDW'(NREQ - 1)) ? '0 : scan_id + IDW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue, tag tracking and response routing. With clk_en low every _d equals
  // its _q, so the whole datapath (and the gated register file) stays aligned.
  // ---------------------------------------------------------------------------
  always_comb begin : p_datapath
    rf_rd_en_d   = rf_rd_en_q;
    rf_rd_addr_d = rf_rd_addr_q;
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    if (clk_en) begin
      for (int k = 0; k < RPORT; k++) begin
        rf_rd_en_d[k] = gnt_vld[k];
        if (gnt_vld[k]) begin
          rf_rd_addr_d[k] = req_addr[gnt_id[k]];
        end
        tag_vld_d[k][0] = gnt_vld[k];
        tag_id_d[k][0]  = gnt_id[k];
        for (int s = 1; s < TD; s++) begin
          tag_vld_d[k][s] = tag_vld_q[k][s-1];
          tag_id_d[k][s]  = tag_id_q[k][s-1];
        end
      end
      // A requester issues at most one read per cycle, so at most one port
      // can target a given requester here; no collision handling is needed.
      rsp_valid_d = '0;
      for (int k = 0; k < RPORT; k++) begin
        if (tag_vld_q[k][TD-1]) begin
          rsp_valid_d[tag_id_q[k][TD-1]] = 1'b1;
          rsp_data_d[tag_id_q[k][TD-1]]  = rf_rd_data[k];
        end
      end
    end
  end

  // Reset wins over clk_en and drops any reads still in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      rf_rd_en_q   <= '0;
      rf_rd_addr_q <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign rf_rd_en   = rf_rd_en_q;
  assign rf_rd_addr = rf_rd_addr_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_vec_rf_rd_arb.sv
// Purpose : directed self-checking bench for vec_rf_rd_arb (NREQ=4, RPORT=2, RF_LAT=1).
// Latency : a handshake at edge E shows rf_rd_en after E and rsp_valid after edge E+2.
// Backpressure: none on responses; the bench model of the register file is gated by clk_en.
module tb_vec_rf_rd_arb;

  localparam int NREQ   = 4;
  localparam int RPORT  = 2;
  localparam int XLEN   = 64;
  localparam int RF_LAT = 1;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       clk_en;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0][4:0]       req_addr;
  logic [NREQ-1:0]            req_ready;
  logic [RPORT-1:0]           rf_rd_en;
  logic [RPORT-1:0][4:0]      rf_rd_addr;
  logic [RPORT-1:0][XLEN-1:0] rf_rd_data = '0;
  logic [NREQ-1:0]            rsp_valid;
  logic [NREQ-1:0][XLEN-1:0]  rsp_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vec_rf_rd_arb #(.NREQ(NREQ), .RPORT(RPORT), .XLEN(XLEN), .RF_LAT(RF_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rf_rd_en   (rf_rd_en),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data)
  );

  // Register-file content: register a holds 0xA0 + a.
  function automatic logic [XLEN-1:0] rf_val(input logic [4:0] a);
    return 64'hA0 + {59'b0, a};
  endfunction

  // One-cycle register file, gated by the same clk_en as the arbiter.
  always @(posedge clk) begin
    if (clk_en) begin
      for (int k = 0; k < RPORT; k++) begin
        if (rf_rd_en[k]) rf_rd_data[k] <= rf_val(rf_rd_addr[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b1; req_valid = '0; req_addr = '0;
    tick(); tick();
    req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    req_valid = '0; rst_n = 1'b1; #1;
    checks++; if (rf_rd_en !== 2'b00) begin errors++; $display("FAIL reset_rf_rd_en: got %b want 00", rf_rd_en); end
    checks++; if (rf_rd_addr !== '0) begin errors++; $display("FAIL reset_rf_rd_addr: got %h want 0", rf_rd_addr); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready: got %b want 0000", req_ready); end
  endtask

  task automatic test_single();
    req_valid = 4'b0001; req_addr[0] = 5'd5; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (rf_rd_en !== 2'b01) begin errors++; $display("FAIL single_rd_en: got %b want 01", rf_rd_en); end
    checks++; if (rf_rd_addr[0] !== 5'd5) begin errors++; $display("FAIL single_rd_addr: got %0d want 5", rf_rd_addr[0]); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_early1: got %b want 0000", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_early2: got %b want 0000", rsp_valid); end
    checks++; if (rf_rd_en !== 2'b00) begin errors++; $display("FAIL single_rd_en_drop: got %b want 00", rf_rd_en); end
    tick();
    checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b want 0001", rsp_valid); end
    checks++; if (rsp_data[0] !== 64'hA5) begin errors++; $display("FAIL single_rsp_data: got %h want a5", rsp_data[0]); end
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_pulse: got %b want 0000", rsp_valid); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_rdy [3];
    int         exp_id0 [3];
    int         exp_id1 [3];
    exp_rdy = '{4'b0011, 4'b1100, 4'b0011};
    exp_id0 = '{0, 2, 0};
    exp_id1 = '{1, 3, 1};
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) req_addr[i] = 5'(8 + i);
    for (int c = 0; c < 5; c++) begin
      req_valid = (c < 3) ? 4'b1111 : 4'b0000; #1;
      if (c < 3) begin
        checks++; if (req_ready !== exp_rdy[c]) begin errors++; $display("FAIL contention_ready[%0d]: got %b want %b", c, req_ready, exp_rdy[c]); end
      end
      tick();
      if (c < 3) begin
        checks++; if (rf_rd_addr[0] !== 5'(8 + exp_id0[c])) begin errors++; $display("FAIL contention_port0[%0d]: got %0d want %0d", c, rf_rd_addr[0], 8 + exp_id0[c]); end
        checks++; if (rf_rd_addr[1] !== 5'(8 + exp_id1[c])) begin errors++; $display("FAIL contention_port1[%0d]: got %0d want %0d", c, rf_rd_addr[1], 8 + exp_id1[c]); end
      end
      if (c >= 2) begin
        checks++; if (rsp_valid !== exp_rdy[c-2]) begin errors++; $display("FAIL contention_rsp_valid[%0d]: got %b want %b", c - 2, rsp_valid, exp_rdy[c-2]); end
        checks++; if (rsp_data[exp_id0[c-2]] !== rf_val(5'(8 + exp_id0[c-2]))) begin errors++; $display("FAIL contention_rsp_data0[%0d]: got %h", c - 2, rsp_data[exp_id0[c-2]]); end
        checks++; if (rsp_data[exp_id1[c-2]] !== rf_val(5'(8 + exp_id1[c-2]))) begin errors++; $display("FAIL contention_rsp_data1[%0d]: got %h", c - 2, rsp_data[exp_id1[c-2]]); end
      end
    end
  endtask

  // Entered with rr_ptr = 2; leaves rr_ptr = 1.
  task automatic test_wrap();
    req_valid = 4'b0100; req_addr[2] = 5'd14; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_pre_ready: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b1011; req_addr[0] = 5'd20; req_addr[1] = 5'd21; req_addr[3] = 5'd23; #1;
    checks++; if (req_ready !== 4'b1001) begin errors++; $display("FAIL wrap_ready: got %b want 1001", req_ready); end
    tick();
    checks++; if (rf_rd_en !== 2'b11) begin errors++; $display("FAIL wrap_rd_en: got %b want 11", rf_rd_en); end
    checks++; if (rf_rd_addr[0] !== 5'd23) begin errors++; $display("FAIL wrap_port0: got %0d want 23", rf_rd_addr[0]); end
    checks++; if (rf_rd_addr[1] !== 5'd20) begin errors++; $display("FAIL wrap_port1: got %0d want 20", rf_rd_addr[1]); end
    req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0110) begin errors++; $display("FAIL wrap_ptr_after: got %b want 0110", req_ready); end
    req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL wrap_pre_rsp: got %b want 0100", rsp_valid); end
    checks++; if (rsp_data[2] !== 64'hAE) begin errors++; $display("FAIL wrap_pre_data: got %h want ae", rsp_data[2]); end
    tick();
    checks++; if (rsp_valid !== 4'b1001) begin errors++; $display("FAIL wrap_rsp_valid: got %b want 1001", rsp_valid); end
    checks++; if (rsp_data[3] !== 64'hB7) begin errors++; $display("FAIL wrap_rsp_data3: got %h want b7", rsp_data[3]); end
    checks++; if (rsp_data[0] !== 64'hB4) begin errors++; $display("FAIL wrap_rsp_data0: got %h want b4", rsp_data[0]); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        req_valid = 4'b0100; req_addr[2] = 5'(c + 1);
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if (c < 4) begin
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 0100", c, req_ready); end
      end
      tick();
      if (c < 4) begin
        checks++; if (rf_rd_en !== 2'b01 || rf_rd_addr[0] !== 5'(c + 1)) begin errors++; $display("FAIL b2b_issue[%0d]: got en %b addr %0d want en 01 addr %0d", c, rf_rd_en, rf_rd_addr[0], c + 1); end
      end
      if (c >= 2) begin
        checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL b2b_rsp_valid[%0d]: got %b want 0100", c - 2, rsp_valid); end
        checks++; if (rsp_data[2] !== rf_val(5'(c - 1))) begin errors++; $display("FAIL b2b_rsp_data[%0d]: got %h want %h", c - 2, rsp_data[2], rf_val(5'(c - 1))); end
      end
    end
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL b2b_end: got %b want 0000", rsp_valid); end
  endtask

  // Entered with rr_ptr = 3.
  task automatic test_clk_en();
    req_valid = 4'b0011; req_addr[0] = 5'd6; req_addr[1] = 5'd7; #1;
    checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL ce_ready: got %b want 0011", req_ready); end
    tick();
    clk_en = 1'b0; req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL ce_gated_ready: got %b want 0000", req_ready); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (rf_rd_en !== 2'b11 || rf_rd_addr[0] !== 5'd6 || rf_rd_addr[1] !== 5'd7) begin errors++; $display("FAIL ce_frozen_rd[%0d]: got en %b addr %0d/%0d want 11 6/7", c, rf_rd_en, rf_rd_addr[0], rf_rd_addr[1]); end
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL ce_frozen_rsp[%0d]: got %b want 0000", c, rsp_valid); end
    end
    clk_en = 1'b1; req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 4'b0000 || rf_rd_en !== 2'b00) begin errors++; $display("FAIL ce_resume: got rsp %b en %b want 0000 00", rsp_valid, rf_rd_en); end
    tick();
    checks++; if (rsp_valid !== 4'b0011) begin errors++; $display("FAIL ce_rsp_valid: got %b want 0011", rsp_valid); end
    checks++; if (rsp_data[0] !== 64'hA6 || rsp_data[1] !== 64'hA7) begin errors++; $display("FAIL ce_rsp_data: got %h/%h want a6/a7", rsp_data[0], rsp_data[1]); end
  endtask

  // Entered with rr_ptr = 2.
  task automatic test_reset_inflight();
    req_valid = 4'b0011; req_addr[0] = 5'd2; req_addr[1] = 5'd3;
    tick();
    req_valid = '0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (rf_rd_en !== 2'b00) begin errors++; $display("FAIL rst_mid_rd_en: got %b want 00", rf_rd_en); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_mid_rsp[%0d]: got %b want 0000", c, rsp_valid); end
    end
    req_valid = 4'b1111; #1;
    checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL rst_mid_ptr: got %b want 0011", req_ready); end
    req_valid = 4'b1000; req_addr[3] = 5'd9; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rst_new_ready: got %b want 1000", req_ready); end
    tick();
    req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_new_early: got %b want 0000", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 4'b1000 || rsp_data[3] !== 64'hA9) begin errors++; $display("FAIL rst_new_rsp: got %b/%h want 1000/a9", rsp_valid, rsp_data[3]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_back_to_back();
    test_clk_en();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
